// File: rtl/iic_req_sched.sv
// Round-robin front end that shares one I2C transaction controller between NREQ requesters.
// Latches the winner's fields, launches the controller, and returns done/err (with a watchdog).
module iic_req_sched #(
    parameter int NREQ    = 4,
    parameter int AW      = 7,
    parameter int RW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 4096,
    localparam int IW     = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_chip,
    input  logic [NREQ*RW-1:0]   req_reg,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      req_done,
    output logic [NREQ-1:0]      req_err,
    output logic                 start_sys,
    output logic [AW-1:0]        tx_chip,
    output logic [RW-1:0]        tx_reg,
    output logic [DW-1:0]        tx_data,
    input  logic                 finish_stop,
    output logic                 abort,
    output logic                 busy,
    output logic [IW-1:0]        grant_id
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [TW-1:0]   timer;

    logic [AW-1:0]   chip_a [NREQ];
    logic [RW-1:0]   reg_a  [NREQ];
    logic [DW-1:0]   data_a [NREQ];

    genvar g;
    for (g = 0; g < NREQ; g++) begin : g_unpack
        assign chip_a[g] = req_chip[g*AW +: AW];
        assign reg_a[g]  = req_reg[g*RW +: RW];
        assign data_a[g] = req_data[g*DW +: DW];
    end

    // First set request at or after ptr, wrapping at NREQ-1.
    logic            found;
    logic [IW-1:0]   sel;
    logic [IW-1:0]   idx;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IW'((int'(ptr) + i) % NREQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    logic [NREQ-1:0] gid_onehot;
    logic [IW-1:0]   ptr_next;

    assign gid_onehot = NREQ'(1) << grant_id;
    assign ptr_next   = (grant_id == IW'(NREQ-1)) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            ptr       <= '0;
            timer     <= '0;
            grant_id  <= '0;
            tx_chip   <= '0;
            tx_reg    <= '0;
            tx_data   <= '0;
            req_ready <= '0;
            req_done  <= '0;
            req_err   <= '0;
            start_sys <= 1'b0;
            abort     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // pulse outputs default low; each state raises only what it owns
            start_sys <= 1'b0;
            req_ready <= '0;
            req_done  <= '0;
            req_err   <= '0;
            abort     <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        tx_chip   <= chip_a[sel];
                        tx_reg    <= reg_a[sel];
                        tx_data   <= data_a[sel];
                        grant_id  <= sel;
                        req_ready <= NREQ'(1) << sel;
                        start_sys <= 1'b1;
                        busy      <= 1'b1;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (finish_stop) begin
                        req_done <= gid_onehot;
                        state    <= DONE;
                    end else if (TIMEOUT != 0 && timer == TLAST) begin
                        req_done <= gid_onehot;
                        req_err  <= gid_onehot;
                        abort    <= 1'b1;
                        state    <= DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DONE: begin
                    ptr   <= ptr_next;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iic_req_sched.sv
// Directed bench for iic_req_sched: two instances (default watchdog and TIMEOUT=16) share stimulus.
module tb_iic_req_sched;

    localparam int NREQ = 4, AW = 7, RW = 8, DW = 8;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_chip;
    logic [NREQ*RW-1:0] req_reg;
    logic [NREQ*DW-1:0] req_data;
    logic               finish_stop;

    logic [NREQ-1:0] a_req_ready, a_req_done, a_req_err;
    logic            a_start_sys, a_abort, a_busy;
    logic [AW-1:0]   a_tx_chip;
    logic [RW-1:0]   a_tx_reg;
    logic [DW-1:0]   a_tx_data;
    logic [1:0]      a_grant_id;

    logic [NREQ-1:0] b_req_ready, b_req_done, b_req_err;
    logic            b_start_sys, b_abort, b_busy;
    logic [AW-1:0]   b_tx_chip;
    logic [RW-1:0]   b_tx_reg;
    logic [DW-1:0]   b_tx_data;
    logic [1:0]      b_grant_id;

    iic_req_sched #(.NREQ(NREQ), .AW(AW), .RW(RW), .DW(DW), .TIMEOUT(4096)) u_dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_chip(req_chip),
        .req_reg(req_reg), .req_data(req_data), .req_ready(a_req_ready),
        .req_done(a_req_done), .req_err(a_req_err), .start_sys(a_start_sys),
        .tx_chip(a_tx_chip), .tx_reg(a_tx_reg), .tx_data(a_tx_data),
        .finish_stop(finish_stop), .abort(a_abort), .busy(a_busy), .grant_id(a_grant_id)
    );

    iic_req_sched #(.NREQ(NREQ), .AW(AW), .RW(RW), .DW(DW), .TIMEOUT(16)) u_t16 (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_chip(req_chip),
        .req_reg(req_reg), .req_data(req_data), .req_ready(b_req_ready),
        .req_done(b_req_done), .req_err(b_req_err), .start_sys(b_start_sys),
        .tx_chip(b_tx_chip), .tx_reg(b_tx_reg), .tx_data(b_tx_data),
        .finish_stop(finish_stop), .abort(b_abort), .busy(b_busy), .grant_id(b_grant_id)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [AW-1:0] chip_of(input int i); return AW'(8'h48 + 4*i); endfunction
    function automatic logic [RW-1:0] reg_of(input int i);  return RW'(8'h08 + 4*i); endfunction
    function automatic logic [DW-1:0] data_of(input int i); return DW'(8'h95 + 8*i); endfunction

    // Asserts reset away from the clock edge and checks it acts before any edge.
    task automatic do_reset();
        finish_stop = 1'b0;
        rstn = 1'b0;
        #2;
        chk("rst_a_ctl", {a_busy, a_start_sys, a_abort, a_req_ready, a_req_done, a_req_err}, 0);
        chk("rst_a_tx", {a_tx_chip, a_tx_reg, a_tx_data}, 0);
        chk("rst_a_gid", a_grant_id, 0);
        chk("rst_b_ctl", {b_busy, b_start_sys, b_abort, b_req_ready, b_req_done, b_req_err}, 0);
        step();
        step();
        chk("rst_hold_done", {a_req_done, b_req_done}, 0);
        rstn = 1'b1;
    endtask

    task automatic wait_start(input bit use16, output int t);
        int n = 0;
        while (((use16 ? b_start_sys : a_start_sys) !== 1'b1) && n < 12) begin
            step();
            n++;
        end
        chk(use16 ? "start_seen16" : "start_seen", use16 ? b_start_sys : a_start_sys, 1);
        t = cyc;
    endtask

    task automatic serve(input int id, input bit drop, input int wcyc, output int ts, output int tf);
        wait_start(0, ts);
        chk("grant_id", a_grant_id, id);
        chk("req_ready", a_req_ready, NREQ'(1) << id);
        chk("tx_fields", {a_tx_chip, a_tx_reg, a_tx_data}, {chip_of(id), reg_of(id), data_of(id)});
        if (drop) req_valid[id[1:0]] = 1'b0;
        repeat (wcyc) step();
        chk("wait_quiet", {a_start_sys, a_req_ready, a_req_done}, 0);
        finish_stop = 1'b1;
        tf = cyc;
        step();
        finish_stop = 1'b0;
        chk("req_done", a_req_done, NREQ'(1) << id);
        chk("req_err", {a_req_err, a_abort}, 0);
        chk("busy_done", a_busy, 1);
        step();
        chk("back_idle", {a_busy, a_req_done}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, c0, ts, tf, fin0;
        req_valid = '0;
        finish_stop = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            req_chip[i*AW +: AW] = chip_of(i);
            req_reg[i*RW +: RW]  = reg_of(i);
            req_data[i*DW +: DW] = data_of(i);
        end
        #1;
        do_reset();

        // single request on requester 2, finish 20 cycles after start_sys
        c0 = cyc;
        req_valid = 4'b0100;
        wait_start(0, t);
        chk("lat_start", t - c0, 1);
        chk("s_grant", a_grant_id, 2);
        chk("s_ready", a_req_ready, 4'b0100);
        chk("s_tx", {a_tx_chip, a_tx_reg, a_tx_data}, {7'h50, 8'h10, 8'hA5});
        chk("s_busy", a_busy, 1);
        req_valid = '0;
        step();
        chk("launch_1cyc", {a_start_sys, a_req_ready}, 0);
        repeat (19) step();
        chk("s_no_early_done", a_req_done, 0);
        chk("s_tx_stable", {a_tx_chip, a_tx_reg, a_tx_data}, {7'h50, 8'h10, 8'hA5});
        finish_stop = 1'b1;
        step();
        finish_stop = 1'b0;
        chk("s_done", a_req_done, 4'b0100);
        chk("s_err", {a_req_err, a_abort}, 0);
        step();
        chk("s_idle", {a_busy, a_req_done}, 0);
        finish_stop = 1'b1;
        step();
        step();
        finish_stop = 1'b0;
        chk("fin_in_idle", {a_busy, a_req_done, a_start_sys}, 0);

        // simultaneous 1011: grants 0,1,3 then ptr wraps back to 0
        do_reset();
        req_valid = 4'b1011;
        serve(0, 1, 3, ts, tf);
        serve(1, 1, 3, ts, tf);
        serve(3, 1, 3, ts, tf);
        repeat (3) step();
        chk("no_extra_grant", {a_busy, a_req_ready}, 0);
        req_valid = 4'b1001;
        serve(0, 1, 2, ts, tf);
        serve(3, 1, 2, ts, tf);

        // all four held continuously: 0,1,2,3,0,1
        do_reset();
        req_valid = 4'b1111;
        serve(0, 0, 2, ts, tf);
        fin0 = tf;
        serve(1, 0, 2, ts, tf);
        chk("b2b_start", ts - fin0, 3);
        serve(2, 0, 2, ts, tf);
        serve(3, 0, 2, ts, tf);
        serve(0, 0, 2, ts, tf);
        serve(1, 0, 2, ts, tf);
        req_valid = '0;

        // TIMEOUT=16, no finish_stop: abort after 16 WAIT cycles
        do_reset();
        req_valid = 4'b0001;
        wait_start(1, t);
        chk("to_grant", b_grant_id, 0);
        chk("to_ready", b_req_ready, 4'b0001);
        req_valid = '0;
        repeat (16) step();
        chk("to_not_yet", {b_req_done, b_abort}, 0);
        step();
        chk("to_done", b_req_done, 4'b0001);
        chk("to_err", b_req_err, 4'b0001);
        chk("to_abort", b_abort, 1);
        step();
        chk("to_after", {b_abort, b_busy, b_req_err, b_req_done}, 0);
        req_valid = 4'b0010;
        wait_start(1, t);
        chk("to_next_grant", b_grant_id, 1);
        req_valid = '0;
        repeat (2) step();
        finish_stop = 1'b1;
        step();
        finish_stop = 1'b0;
        chk("to_next_done", b_req_done, 4'b0010);
        chk("to_next_ok", {b_req_err, b_abort}, 0);

        // TIMEOUT=16, finish_stop on the 16th WAIT cycle wins
        do_reset();
        req_valid = 4'b0001;
        wait_start(1, t);
        req_valid = '0;
        repeat (16) step();
        finish_stop = 1'b1;
        step();
        finish_stop = 1'b0;
        chk("edge_done", b_req_done, 4'b0001);
        chk("edge_ok", {b_req_err, b_abort}, 0);

        // reset mid-WAIT: no req_done, request granted again afterwards
        do_reset();
        req_valid = 4'b0010;
        wait_start(0, t);
        chk("mr_grant", a_grant_id, 1);
        repeat (5) step();
        chk("mr_in_wait", a_busy, 1);
        do_reset();
        wait_start(0, t);
        chk("mr_regrant", a_grant_id, 1);
        chk("mr_ready", a_req_ready, 4'b0010);
        req_valid = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
